// File: rtl/board_move_engine.sv
`default_nettype none
// ============================================================================
// Module   : board_move_engine
// Summary  : Runs one Othello-style move against the board memory: occupancy
//            check, eight-direction scan, per-direction flip, then placement.
// Revision : 1.0 - initial release
// ============================================================================
module board_move_engine #(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 8,
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = $clog2(WIDTH * HEIGHT)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(WIDTH)-1:0]   moveX,
    input  logic [$clog2(HEIGHT)-1:0]  moveY,
    input  logic [1:0]                 player,
    output logic [$clog2(WIDTH)-1:0]   readX,
    output logic [$clog2(HEIGHT)-1:0]  readY,
    input  logic [BUS_WIDTH-1:0]       readValue,
    output logic                       writeEn,
    output logic [$clog2(WIDTH)-1:0]   writeX,
    output logic [$clog2(HEIGHT)-1:0]  writeY,
    output logic [BUS_WIDTH-1:0]       writeValue,
    output logic                       busy,
    output logic                       done,
    output logic                       legal,
    output logic [CNT_WIDTH-1:0]       flipCount
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_DIR_INIT = 3'd2;
    localparam logic [2:0] S_SCAN     = 3'd3;
    localparam logic [2:0] S_FLIP     = 3'd4;
    localparam logic [2:0] S_NEXT_DIR = 3'd5;
    localparam logic [2:0] S_PLACE    = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [XW:0]        X_LIMIT = (XW + 1)'(WIDTH);
    localparam logic [YW:0]        Y_LIMIT = (YW + 1)'(HEIGHT);
    localparam logic signed [XW:0] X_POS   = {{XW{1'b0}}, 1'b1};
    localparam logic signed [XW:0] X_NEG   = {(XW + 1){1'b1}};
    localparam logic signed [YW:0] Y_POS   = {{YW{1'b0}}, 1'b1};
    localparam logic signed [YW:0] Y_NEG   = {(YW + 1){1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH - 1){1'b0}}, 1'b1};

    logic [2:0]             state;
    logic [XW-1:0]          origin_x;
    logic [YW-1:0]          origin_y;
    logic [1:0]             mover;
    logic [2:0]             dir;
    logic signed [XW:0]     cur_x;
    logic signed [YW:0]     cur_y;
    logic [CNT_WIDTH-1:0]   run;
    logic [CNT_WIDTH-1:0]   flip_count;
    logic                   legal_r;

    logic signed [XW:0]     step_x;
    logic signed [YW:0]     step_y;
    logic [BUS_WIDTH-1:0]   own_code;
    logic [BUS_WIDTH-1:0]   opp_code;
    logic                   off_board;
    logic                   is_opp;
    logic                   is_own;

    // Direction table, y grows downward: E, SE, S, SW, W, NW, N, NE
    always_comb begin
        step_x = '0;
        step_y = '0;
        case (dir)
            3'd0: begin step_x = X_POS; step_y = '0;    end
            3'd1: begin step_x = X_POS; step_y = Y_POS; end
            3'd2: begin step_x = '0;    step_y = Y_POS; end
            3'd3: begin step_x = X_NEG; step_y = Y_POS; end
            3'd4: begin step_x = X_NEG; step_y = '0;    end
            3'd5: begin step_x = X_NEG; step_y = Y_NEG; end
            3'd6: begin step_x = '0;    step_y = Y_NEG; end
            default: begin step_x = X_POS; step_y = Y_NEG; end
        endcase
    end

    assign own_code  = BUS_WIDTH'(mover);
    assign opp_code  = BUS_WIDTH'(2'd3 - mover);
    assign is_own    = (readValue == own_code);
    assign is_opp    = (readValue == opp_code);

    // One step past the far edge wraps into the sign bit, so the sign test
    // alone catches both the negative and the power-of-two overflow cases.
    assign off_board = cur_x[XW] || cur_y[YW] ||
                       ({1'b0, cur_x[XW-1:0]} >= X_LIMIT) ||
                       ({1'b0, cur_y[YW-1:0]} >= Y_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            origin_x   <= '0;
            origin_y   <= '0;
            mover      <= '0;
            dir        <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            run        <= '0;
            flip_count <= '0;
            legal_r    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        origin_x   <= moveX;
                        origin_y   <= moveY;
                        mover      <= player;
                        flip_count <= '0;
                        legal_r    <= 1'b0;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (readValue != '0) begin
                        state <= S_DONE;
                    end else begin
                        dir   <= '0;
                        state <= S_DIR_INIT;
                    end
                end
                S_DIR_INIT: begin
                    cur_x <= $signed({1'b0, origin_x}) + step_x;
                    cur_y <= $signed({1'b0, origin_y}) + step_y;
                    run   <= '0;
                    state <= S_SCAN;
                end
                S_SCAN: begin
                    if (off_board || !(is_opp || is_own)) begin
                        state <= S_NEXT_DIR;
                    end else if (is_opp) begin
                        run   <= run + CNT_ONE;
                        cur_x <= cur_x + step_x;
                        cur_y <= cur_y + step_y;
                    end else if (run != '0) begin
                        cur_x <= cur_x - step_x;
                        cur_y <= cur_y - step_y;
                        state <= S_FLIP;
                    end else begin
                        state <= S_NEXT_DIR;
                    end
                end
                S_FLIP: begin
                    flip_count <= flip_count + CNT_ONE;
                    run        <= run - CNT_ONE;
                    cur_x      <= cur_x - step_x;
                    cur_y      <= cur_y - step_y;
                    if (run == CNT_ONE) begin
                        state <= S_NEXT_DIR;
                    end
                end
                S_NEXT_DIR: begin
                    if (dir == 3'd7) begin
                        state <= (flip_count != '0) ? S_PLACE : S_DONE;
                    end else begin
                        dir   <= dir + 3'd1;
                        state <= S_DIR_INIT;
                    end
                end
                S_PLACE: begin
                    legal_r <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // During writes the read port is parked on a cell that is never the
    // write target: the (still empty) origin while flipping, its x-neighbour
    // while placing.
    always_comb begin
        readX = cur_x[XW-1:0];
        readY = cur_y[YW-1:0];
        case (state)
            S_CHECK, S_FLIP: begin
                readX = origin_x;
                readY = origin_y;
            end
            S_PLACE: begin
                readX = origin_x ^ XW'(1);
                readY = origin_y;
            end
            default: begin
            end
        endcase
    end

    assign writeEn    = (state == S_FLIP) || (state == S_PLACE);
    assign writeX     = (state == S_PLACE) ? origin_x : cur_x[XW-1:0];
    assign writeY     = (state == S_PLACE) ? origin_y : cur_y[YW-1:0];
    assign writeValue = own_code;
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);
    assign legal      = legal_r;
    assign flipCount  = flip_count;

endmodule
`default_nettype wire

// File: tb/tb_board_move_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_move_engine
// Summary  : Self-checking bench: board memory model, reference move model
//            feeding an expected-write scoreboard, directed and random moves.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_move_engine;

    localparam int W     = 8;
    localparam int H     = 8;
    localparam int BW    = 8;
    localparam int CW    = 6;
    localparam int LIMIT = 400;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    moveX, moveY;
    logic [1:0]    player;
    logic [2:0]    readX, readY, writeX, writeY;
    logic [BW-1:0] readValue, writeValue;
    logic          writeEn, busy, done, legal;
    logic [CW-1:0] flipCount;

    logic [7:0]    board [0:H-1][0:W-1];
    logic [13:0]   exp_wr_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;

    int            r_lat, r_done_cnt, r_busy_done, r_timeout;
    logic          r_legal, r_hold_legal;
    logic [CW-1:0] r_cnt, r_hold_cnt;

    board_move_engine #(.WIDTH(W), .HEIGHT(H), .BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .moveX(moveX), .moveY(moveY),
        .player(player), .readX(readX), .readY(readY), .readValue(readValue),
        .writeEn(writeEn), .writeX(writeX), .writeY(writeY), .writeValue(writeValue),
        .busy(busy), .done(done), .legal(legal), .flipCount(flipCount)
    );

    always #5 clk = ~clk;

    assign readValue = board[readY][readX];

    function automatic logic [13:0] pack(input int x, input int y, input int v);
        logic [13:0] r;
        r = {x[2:0], y[2:0], v[7:0]};
        return r;
    endfunction

    // Scoreboard consumer: each board write is popped and checked, then applied.
    always @(negedge clk) begin
        if (reset !== 1'b1 && writeEn === 1'b1) begin
            logic [13:0] e;
            n_cmp++;
            if (exp_wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write got x=%0d y=%0d v=%0d, no write expected", writeX, writeY, writeValue);
            end else begin
                e = exp_wr_q.pop_front();
                if ({writeX, writeY, writeValue} !== e)
                    begin n_fail++; $display("FAIL write_order got x=%0d y=%0d v=%0d want x=%0d y=%0d v=%0d", writeX, writeY, writeValue, e[13:11], e[10:8], e[7:0]); end
            end
            n_cmp++;
            if ({readX, readY} === {writeX, writeY})
                begin n_fail++; $display("FAIL rd_wr_collide got read=(%0d,%0d) write=(%0d,%0d) want distinct", readX, readY, writeX, writeY); end
            board[writeY][writeX] = writeValue;
        end
    end

    task automatic clear_board();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                board[y][x] = 8'd0;
    endtask

    // Reference move: pushes expected writes, returns legality, count, latency.
    task automatic model_move(input int x, input int y, input int p,
                              output int e_legal, output int e_cnt, output int e_lat);
        int dxs[8];
        int dys[8];
        int n, cx, cy;
        dxs = '{1, 1, 0, -1, -1, -1, 0, 1};
        dys = '{0, 1, 1, 1, 0, -1, -1, -1};
        exp_wr_q.delete();
        e_cnt = 0;
        e_lat = 2;
        e_legal = 0;
        if (board[y][x] != 8'd0) return;
        for (int d = 0; d < 8; d++) begin
            n = 0; cx = x + dxs[d]; cy = y + dys[d];
            while (cx >= 0 && cx < W && cy >= 0 && cy < H && board[cy][cx] == 3 - p) begin
                n++; cx += dxs[d]; cy += dys[d];
            end
            e_lat += 3 + n;
            if (n > 0 && cx >= 0 && cx < W && cy >= 0 && cy < H && board[cy][cx] == p) begin
                for (int k = n; k >= 1; k--)
                    exp_wr_q.push_back(pack(x + k * dxs[d], y + k * dys[d], p));
                e_cnt += n;
                e_lat += n;
            end
        end
        if (e_cnt > 0) begin
            exp_wr_q.push_back(pack(x, y, p));
            e_lat += 1;
            e_legal = 1;
        end
    endtask

    // Drives one request and records what the DUT reports; extra_at > 0 pulses
    // a second, different start at that cycle of the move.
    task automatic do_move(input int x, input int y, input int p, input int extra_at);
        @(negedge clk);
        moveX = x[2:0]; moveY = y[2:0]; player = p[1:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r_lat = 0; r_done_cnt = 0; r_busy_done = 1; r_timeout = 1;
        r_legal = 1'bx; r_cnt = 'x;
        for (int k = 1; k <= LIMIT; k++) begin
            if (k == extra_at) begin
                moveX = 3'(x + 3); moveY = 3'(y + 2); player = 2'(3 - p); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                r_lat = k; r_done_cnt = 1; r_busy_done = int'(busy);
                r_legal = legal; r_cnt = flipCount; r_timeout = 0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) r_done_cnt++;
        end
        r_hold_legal = legal;
        r_hold_cnt   = flipCount;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; moveX = '0; moveY = '0; player = '0;
        clear_board();
        @(negedge clk);
        n_cmp++;
        if ({readX, readY, writeEn, writeX, writeY, writeValue, busy, done, legal, flipCount} !== '0)
            begin n_fail++; $display("FAIL reset_outputs got busy=%b done=%b wen=%b legal=%b cnt=%0d want all 0", busy, done, writeEn, legal, flipCount); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin n_fail++; $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_occupied();
        int el, ec, lat;
        clear_board();
        board[3][3] = 8'd2;
        model_move(3, 3, 1, el, ec, lat);
        do_move(3, 3, 1, 0);
        n_cmp++; if (r_timeout != 0) begin n_fail++; $display("FAIL occ_timeout got timeout want done"); end
        n_cmp++; if (r_legal !== 1'b0) begin n_fail++; $display("FAIL occ_legal got %b want 0", r_legal); end
        n_cmp++; if (r_cnt !== 6'd0) begin n_fail++; $display("FAIL occ_count got %0d want 0", r_cnt); end
        n_cmp++; if (r_lat != 2) begin n_fail++; $display("FAIL occ_latency got %0d want 2", r_lat); end
    endtask

    task automatic setup_opening();
        clear_board();
        board[3][3] = 8'd2; board[4][4] = 8'd2;
        board[4][3] = 8'd1; board[3][4] = 8'd1;
    endtask

    task automatic test_opening();
        int el, ec, lat;
        setup_opening();
        model_move(2, 3, 1, el, ec, lat);
        do_move(2, 3, 1, 0);
        n_cmp++; if (r_timeout != 0) begin n_fail++; $display("FAIL open_timeout got timeout want done"); end
        n_cmp++; if (r_legal !== 1'b1) begin n_fail++; $display("FAIL open_legal got %b want 1", r_legal); end
        n_cmp++; if (r_cnt !== 6'd1) begin n_fail++; $display("FAIL open_count got %0d want 1", r_cnt); end
        n_cmp++; if (r_lat != lat) begin n_fail++; $display("FAIL open_latency got %0d want %0d", r_lat, lat); end
        n_cmp++; if (r_busy_done != 0) begin n_fail++; $display("FAIL open_busy_at_done got %0d want 0", r_busy_done); end
        n_cmp++; if (exp_wr_q.size() != 0) begin n_fail++; $display("FAIL open_missing_writes got %0d left want 0", exp_wr_q.size()); end
        n_cmp++; if (r_hold_legal !== 1'b1 || r_hold_cnt !== 6'd1) begin n_fail++; $display("FAIL open_hold got legal=%b cnt=%0d want 1 1", r_hold_legal, r_hold_cnt); end
        n_cmp++; if (board[3][3] !== 8'd1 || board[3][2] !== 8'd1) begin n_fail++; $display("FAIL open_board got (3,3)=%0d (2,3)=%0d want 1 1", board[3][3], board[3][2]); end
    endtask

    task automatic test_corner();
        int el, ec, lat;
        clear_board();
        board[0][1] = 8'd2; board[0][2] = 8'd1; board[1][1] = 8'd2;
        board[2][2] = 8'd2; board[3][3] = 8'd1;
        model_move(0, 0, 1, el, ec, lat);
        do_move(0, 0, 1, 0);
        n_cmp++; if (r_legal !== 1'b1) begin n_fail++; $display("FAIL corner_legal got %b want 1", r_legal); end
        n_cmp++; if (r_cnt !== 6'd3) begin n_fail++; $display("FAIL corner_count got %0d want 3", r_cnt); end
        n_cmp++; if (r_lat != lat) begin n_fail++; $display("FAIL corner_latency got %0d want %0d", r_lat, lat); end
        n_cmp++; if (exp_wr_q.size() != 0) begin n_fail++; $display("FAIL corner_missing_writes got %0d left want 0", exp_wr_q.size()); end
    endtask

    task automatic test_edge_offboard();
        int el, ec, lat;
        clear_board();
        for (int x = 0; x < 7; x++) board[7][x] = 8'd2;
        model_move(7, 7, 1, el, ec, lat);
        do_move(7, 7, 1, 0);
        n_cmp++; if (r_timeout != 0) begin n_fail++; $display("FAIL edge_timeout got timeout want done"); end
        n_cmp++; if (r_legal !== 1'b0 || r_cnt !== 6'd0) begin n_fail++; $display("FAIL edge_result got legal=%b cnt=%0d want 0 0", r_legal, r_cnt); end
        n_cmp++; if (r_lat != lat) begin n_fail++; $display("FAIL edge_latency got %0d want %0d", r_lat, lat); end
        n_cmp++; if (board[7][0] !== 8'd2 || board[7][7] !== 8'd0) begin n_fail++; $display("FAIL edge_board got (0,7)=%0d (7,7)=%0d want 2 0", board[7][0], board[7][7]); end
    endtask

    task automatic test_busy_restart();
        int el, ec, lat;
        setup_opening();
        model_move(2, 3, 1, el, ec, lat);
        do_move(2, 3, 1, 4);
        n_cmp++; if (r_legal !== 1'b1 || r_cnt !== 6'd1) begin n_fail++; $display("FAIL restart_result got legal=%b cnt=%0d want 1 1", r_legal, r_cnt); end
        n_cmp++; if (r_lat != lat) begin n_fail++; $display("FAIL restart_latency got %0d want %0d", r_lat, lat); end
        n_cmp++; if (r_done_cnt != 1) begin n_fail++; $display("FAIL restart_done_pulses got %0d want 1", r_done_cnt); end
        n_cmp++; if (r_busy_done != 0) begin n_fail++; $display("FAIL restart_busy_at_done got %0d want 0", r_busy_done); end
        n_cmp++; if (exp_wr_q.size() != 0) begin n_fail++; $display("FAIL restart_missing_writes got %0d left want 0", exp_wr_q.size()); end
    endtask

    task automatic test_reset_mid_scan();
        setup_opening();
        exp_wr_q.delete();
        @(negedge clk);
        moveX = 3'd2; moveY = 3'd3; player = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midscan_busy got %b want 1", busy); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({readX, readY, writeEn, writeX, writeY, writeValue, busy, done, legal, flipCount} !== '0)
            begin n_fail++; $display("FAIL midscan_reset_outputs got busy=%b wen=%b wval=%0d rx=%0d want all 0", busy, writeEn, writeValue, readX); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (board[3][3] !== 8'd2 || board[3][2] !== 8'd0) begin n_fail++; $display("FAIL midscan_board got (3,3)=%0d (2,3)=%0d want 2 0", board[3][3], board[3][2]); end
    endtask

    task automatic test_random();
        int el, ec, lat, x, y, p, v;
        for (int it = 0; it < 10; it++) begin
            for (int yy = 0; yy < H; yy++)
                for (int xx = 0; xx < W; xx++) begin
                    v = int'($urandom_range(0, 9));
                    board[yy][xx] = (v < 4) ? 8'd0 : (v < 7) ? 8'd1 : (v < 9) ? 8'd2 : 8'd3;
                end
            x = int'($urandom_range(0, W - 1));
            y = int'($urandom_range(0, H - 1));
            p = int'($urandom_range(1, 2));
            if (it % 4 != 3) board[y][x] = 8'd0;
            model_move(x, y, p, el, ec, lat);
            do_move(x, y, p, 0);
            n_cmp++;
            if (r_timeout != 0 || r_legal !== 1'(el) || r_cnt !== CW'(ec) || r_lat != lat)
                begin n_fail++; $display("FAIL rand_result it=%0d got legal=%b cnt=%0d lat=%0d want %0d %0d %0d", it, r_legal, r_cnt, r_lat, el, ec, lat); end
            n_cmp++;
            if (exp_wr_q.size() != 0)
                begin n_fail++; $display("FAIL rand_missing_writes it=%0d got %0d left want 0", it, exp_wr_q.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_occupied();
        test_opening();
        test_corner();
        test_edge_offboard();
        test_busy_restart();
        test_reset_mid_scan();
        test_opening();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
